// File: rtl/sdpram_rd_streamer.sv
// sdpram_rd_streamer
//   Read-side engine for a distributed simple-dual-port RAM. A start command
//   loads a base address and a word count; the block then walks the RAM read
//   address across that window and returns the words as a valid/ready stream
//   with a last flag. A 2-entry skid FIFO absorbs sink back-pressure. Reads
//   are issued only when the FIFO is guaranteed to have room, so no word is
//   dropped and, with the sink always ready, there are no bubbles.
//
// Parameters
//   ADDR_WIDTH  RAM address width (4..10)
//   DATA_WIDTH  RAM data width (1..256)
//   RD_LAT      RAM read latency: 0 = unregistered output, 1 = registered
//
// Ports
//   rd_clk       single clock for all logic
//   rst          synchronous, active-high reset
//   start        one-cycle command strobe, honoured only in IDLE
//   base_addr    first RAM address to read (sampled with start)
//   xfer_len     words to read, 0..2**ADDR_WIDTH (sampled with start)
//   busy         transfer in progress
//   done         one-cycle pulse at end of transfer
//   ram_rd_addr  registered RAM read address
//   ram_rd_data  RAM read data
//   m_data       stream data (FIFO head)
//   m_valid      stream valid
//   m_last       final word of the transfer
//   m_ready      stream sink ready
//   stall_cnt    cycles with m_valid=1, m_ready=0 during a transfer
//                (present only when SDPRAM_RD_STALL_CNT_EN is defined)
//
// State table
//   IDLE  | waiting for start
//   RUN   | issuing RAM reads while words remain
//   DRAIN | all reads issued; waiting for FIFO and pipeline to empty

module sdpram_rd_streamer #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 4,
    parameter int RD_LAT     = 0
) (
    input  logic                  rd_clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   xfer_len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready
`ifdef SDPRAM_RD_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH:0] LEN_ZERO = '0;
    localparam logic [ADDR_WIDTH:0] LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_WIDTH:0]     remaining_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    zero_done_q;

    logic [DATA_WIDTH-1:0]   fifo_data [2];
    logic                    fifo_last [2];
    logic                    wr_ptr_q;
    logic                    rd_ptr_q;
    logic [1:0]              occ_q;

    logic                    start_ok;
    logic                    pop;
    logic                    issue;
    logic                    issue_last;
    logic                    inflight;
    logic                    push;
    logic                    push_last;
    logic                    drain_done;
    logic [2:0]              occ_proj;

    assign start_ok   = (state_q == IDLE) && start;
    assign m_valid    = (occ_q != 2'd0);
    assign pop        = m_valid && m_ready;
    assign issue_last = (remaining_q == LEN_ONE);

    // Occupancy the FIFO will have once everything already in the RAM
    // pipeline has landed and this cycle's pop is taken out. pop implies
    // occ_q > 0, so this never underflows.
    assign occ_proj = {1'b0, occ_q} + {2'b00, inflight} - {2'b00, pop};
    assign issue    = (state_q == RUN) && (remaining_q != LEN_ZERO) && (occ_proj < 3'd2);

    assign drain_done = (state_q == DRAIN) && (occ_q == 2'd0) && !inflight;

    assign busy        = (state_q != IDLE);
    assign done        = zero_done_q || drain_done;
    assign ram_rd_addr = addr_q;
    assign m_data      = fifo_data[rd_ptr_q];
    assign m_last      = m_valid && fifo_last[rd_ptr_q];

    // Data alignment with the RAM read latency
    if (RD_LAT == 0) begin : g_lat0
        assign inflight  = 1'b0;
        assign push      = issue;
        assign push_last = issue_last;
    end else begin : g_lat1
        logic inflight_q;
        logic inflight_last_q;

        always_ff @(posedge rd_clk) begin
            if (rst) begin
                inflight_q      <= 1'b0;
                inflight_last_q <= 1'b0;
            end else begin
                inflight_q      <= issue;
                inflight_last_q <= issue && issue_last;
            end
        end

        assign inflight  = inflight_q;
        assign push      = inflight_q;
        assign push_last = inflight_last_q;
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start && (xfer_len != LEN_ZERO)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (issue && issue_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            addr_q      <= '0;
            remaining_q <= '0;
            zero_done_q <= 1'b0;
        end else begin
            zero_done_q <= start_ok && (xfer_len == LEN_ZERO);
            if (start_ok) begin
                if (xfer_len != LEN_ZERO) begin
                    addr_q      <= base_addr;
                    remaining_q <= xfer_len;
                end
            end else if (issue) begin
                addr_q      <= addr_q + 1'b1;
                remaining_q <= remaining_q - LEN_ONE;
            end
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr_q] <= ram_rd_data;
                fifo_last[wr_ptr_q] <= push_last;
                wr_ptr_q            <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

`ifdef SDPRAM_RD_STALL_CNT_EN
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (start_ok) begin
            stall_cnt <= '0;
        end else if (busy && m_valid && !m_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sdpram_rd_streamer.sv
// Bench for sdpram_rd_streamer. Two instances run side by side from the same
// command stimulus: instance 0 with RD_LAT=0 and instance 1 with RD_LAT=1,
// each reading its own RAM model preloaded with mem[i]=i. Expected beats are
// queued per instance when a transfer is launched; a negedge monitor pops and
// compares on every handshake.

module tb_sdpram_rd_streamer;

    localparam int AW = 4;
    localparam int DW = 4;

    logic          rd_clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   xfer_len = '0;
    logic          m_ready = 1'b1;

    logic          busy_0, done_0, m_valid_0, m_last_0;
    logic          busy_1, done_1, m_valid_1, m_last_1;
    logic [AW-1:0] ram_rd_addr_0, ram_rd_addr_1;
    logic [DW-1:0] ram_rd_data_0, ram_rd_data_1;
    logic [DW-1:0] m_data_0, m_data_1;
`ifdef SDPRAM_RD_STALL_CNT_EN
    logic [15:0]   stall_cnt_0, stall_cnt_1;
`endif

    always #5 rd_clk = ~rd_clk;

    sdpram_rd_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(0)) u_lat0 (
        .rd_clk(rd_clk), .rst(rst), .start(start), .base_addr(base_addr),
        .xfer_len(xfer_len), .busy(busy_0), .done(done_0),
        .ram_rd_addr(ram_rd_addr_0), .ram_rd_data(ram_rd_data_0),
        .m_data(m_data_0), .m_valid(m_valid_0), .m_last(m_last_0),
        .m_ready(m_ready)
`ifdef SDPRAM_RD_STALL_CNT_EN
        , .stall_cnt(stall_cnt_0)
`endif
    );

    sdpram_rd_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(1)) u_lat1 (
        .rd_clk(rd_clk), .rst(rst), .start(start), .base_addr(base_addr),
        .xfer_len(xfer_len), .busy(busy_1), .done(done_1),
        .ram_rd_addr(ram_rd_addr_1), .ram_rd_data(ram_rd_data_1),
        .m_data(m_data_1), .m_valid(m_valid_1), .m_last(m_last_1),
        .m_ready(m_ready)
`ifdef SDPRAM_RD_STALL_CNT_EN
        , .stall_cnt(stall_cnt_1)
`endif
    );

    // RAM models: combinational read for instance 0, registered for instance 1
    logic [DW-1:0] mem [16];
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = DW'(i);
    end
    assign ram_rd_data_0 = mem[ram_rd_addr_0];
    always @(posedge rd_clk) ram_rd_data_1 <= mem[ram_rd_addr_1];

    int cyc = 0;
    int start_cyc = 0;
    int rdy_mode = 0;
    always @(posedge rd_clk) cyc <= cyc + 1;

    // Sink ready: mode 0 always ready, mode 1 pattern 1,0,0 repeating
    always @(posedge rd_clk) begin
        #1;
        if (rdy_mode == 0) m_ready = 1'b1;
        else               m_ready = (((cyc - start_cyc) % 3) == 0);
    end

    int nchecks = 0;
    int nerrors = 0;

    logic [DW:0] q0 [$];
    logic [DW:0] q1 [$];

    int nbeats [2];
    int ndone [2];
    int first_valid [2];
    int first_beat [2];
    int last_beat [2];
    int done_cyc [2];
    int busy_first [2];
    int stalls [2];
    bit prev_st [2];
    logic [DW-1:0] prev_d [2];
    logic prev_l [2];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 2; i++) begin
            nbeats[i] = 0; ndone[i] = 0; first_valid[i] = -1; first_beat[i] = -1;
            last_beat[i] = -1; done_cyc[i] = -1; busy_first[i] = -1; stalls[i] = 0;
        end
    endtask

    task automatic mon(input int i, input logic v, input logic r, input logic [DW-1:0] d,
                       input logic l, input logic b, input logic dn);
        int c;
        bit have;
        logic [DW:0] e;
        c = cyc - start_cyc + 1;
        if (!rst && prev_st[i]) begin
            nchecks++;
            if (!v || d !== prev_d[i] || l !== prev_l[i]) begin
                nerrors++;
                $display("FAIL stall_hold[%0d]: got v=%0b d=%0d l=%0b expected v=1 d=%0d l=%0b",
                         i, v, d, l, prev_d[i], prev_l[i]);
            end
        end
        prev_st[i] = v && !r && !rst;
        prev_d[i]  = d;
        prev_l[i]  = l;
        if (v && first_valid[i] < 0) first_valid[i] = c;
        if (b && busy_first[i] < 0) busy_first[i] = c;
        if (v && !r && b) stalls[i]++;
        if (v && r) begin
            have = 1'b0;
            e = '0;
            if (i == 0) begin
                if (q0.size() != 0) begin have = 1'b1; e = q0.pop_front(); end
            end else begin
                if (q1.size() != 0) begin have = 1'b1; e = q1.pop_front(); end
            end
            nchecks++;
            if (!have) begin
                nerrors++;
                $display("FAIL unexpected_beat[%0d]: got d=%0d l=%0b expected no beat", i, d, l);
            end else if ({l, d} !== e) begin
                nerrors++;
                $display("FAIL beat[%0d]: got d=%0d l=%0b expected d=%0d l=%0b",
                         i, d, l, e[DW-1:0], e[DW]);
            end
            if (nbeats[i] == 0) first_beat[i] = c;
            last_beat[i] = c;
            nbeats[i]++;
        end
        if (dn) begin
            ndone[i]++;
            done_cyc[i] = c;
        end
    endtask

    always @(negedge rd_clk) begin
        mon(0, m_valid_0, m_ready, m_data_0, m_last_0, busy_0, done_0);
        mon(1, m_valid_1, m_ready, m_data_1, m_last_1, busy_1, done_1);
    end

    function automatic string nm(input string s, input int i);
        return $sformatf("%s[%0d]", s, i);
    endfunction

    task automatic queue_words(input int b, input int len);
        logic [DW:0] e;
        for (int k = 0; k < len; k++) begin
            e = {(k == len - 1), DW'((b + k) % 16)};
            q0.push_back(e);
            q1.push_back(e);
        end
    endtask

    task automatic launch(input int b, input int len);
        @(posedge rd_clk); #1;
        start = 1'b1; base_addr = AW'(b); xfer_len = (AW+1)'(len);
        @(posedge rd_clk); #1;
        start_cyc = cyc;
        start = 1'b0;
        clear_stats();
    endtask

    task automatic run_xfer(input int b, input int len, input int mode, input bit dup);
        int t;
        rdy_mode = mode;
        queue_words(b, len);
        launch(b, len);
        if (dup) begin
            repeat (2) @(posedge rd_clk);
            #1; start = 1'b1; base_addr = '0; xfer_len = (AW+1)'(3);
            @(posedge rd_clk); #1; start = 1'b0;
        end
        t = 0;
        while (t < 200 && !(ndone[0] > 0 && ndone[1] > 0)) begin
            @(posedge rd_clk); #1;
            t++;
        end
        if (t >= 200) begin
            nerrors++;
            $display("FAIL done_timeout: got done0=%0d done1=%0d expected 1", ndone[0], ndone[1]);
        end
        repeat (3) @(posedge rd_clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk(nm("queue_left", i), (i == 0) ? q0.size() : q1.size(), 0);
            chk(nm("beats", i), nbeats[i], len);
            chk(nm("done_pulses", i), ndone[i], 1);
            chk(nm("busy_after", i), (i == 0) ? busy_0 : busy_1, 0);
            if (len > 0) begin
                chk(nm("first_valid_cyc", i), first_valid[i], 2 + i);
                chk(nm("busy_first_cyc", i), busy_first[i], 1);
                chk(nm("done_after_last", i), done_cyc[i], last_beat[i] + 1);
                if (mode == 0) chk(nm("back_to_back", i), last_beat[i] - first_beat[i], len - 1);
            end else begin
                chk(nm("zero_done_cyc", i), done_cyc[i], 1);
                chk(nm("zero_busy_seen", i), busy_first[i], -1);
                chk(nm("zero_valid_seen", i), first_valid[i], -1);
            end
`ifdef SDPRAM_RD_STALL_CNT_EN
            chk(nm("stall_cnt", i), (i == 0) ? stall_cnt_0 : stall_cnt_1, stalls[i]);
`endif
        end
        q0.delete();
        q1.delete();
    endtask

    initial begin
        int t;
        clear_stats();
        for (int i = 0; i < 2; i++) prev_st[i] = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge rd_clk);
        #1;
        chk("rst_busy_0", busy_0, 0);           chk("rst_busy_1", busy_1, 0);
        chk("rst_done_0", done_0, 0);           chk("rst_done_1", done_1, 0);
        chk("rst_valid_0", m_valid_0, 0);       chk("rst_valid_1", m_valid_1, 0);
        chk("rst_last_0", m_last_0, 0);         chk("rst_last_1", m_last_1, 0);
        chk("rst_data_0", m_data_0, 0);         chk("rst_data_1", m_data_1, 0);
        chk("rst_addr_0", ram_rd_addr_0, 0);    chk("rst_addr_1", ram_rd_addr_1, 0);
        rst = 1'b0;
        repeat (2) @(posedge rd_clk);

        run_xfer(3, 5, 0, 1'b0);     // beats 3..7, last on 7
        run_xfer(14, 4, 0, 1'b0);    // wrap: 14,15,0,1
        run_xfer(2, 8, 1, 1'b0);     // back-pressure
        run_xfer(5, 0, 0, 1'b0);     // zero length
        run_xfer(4, 6, 0, 1'b1);     // second start while busy is ignored
        run_xfer(9, 16, 0, 1'b0);    // full window: 9..15,0..8

        // Reset in the middle of a 10-word transfer
        rdy_mode = 0;
        queue_words(0, 10);
        launch(0, 10);
        t = 0;
        while (t < 50 && nbeats[0] < 3) begin
            @(posedge rd_clk); #1;
            t++;
        end
        if (t >= 50) begin
            nerrors++;
            $display("FAIL mid_rst_wait: got %0d beats expected 3", nbeats[0]);
        end
        rst = 1'b1;
        @(posedge rd_clk); #1;
        rst = 1'b0;
        q0.delete();
        q1.delete();
        chk("mid_rst_valid_0", m_valid_0, 0);   chk("mid_rst_valid_1", m_valid_1, 0);
        chk("mid_rst_busy_0", busy_0, 0);       chk("mid_rst_busy_1", busy_1, 0);
        repeat (5) @(posedge rd_clk);
        #1;
        chk("mid_rst_no_done_0", ndone[0], 0);  chk("mid_rst_no_done_1", ndone[1], 0);
        run_xfer(0, 2, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
        $finish;
    end

endmodule

// File: doc/sdpram_rd_streamer.md
Name: sdpram_rd_streamer

Overview:
- Read-side engine for the distributed simple-dual-port RAM.
- The write side fills the RAM on its own clock. This block is started by a command, drives the RAM read address across a programmed window, and returns the words as a valid/ready stream with a last flag.
- It tracks RAM read latency (0 or 1 cycle) and absorbs output back-pressure in a 2-entry skid FIFO, so the stream carries no bubbles and drops no data.

Parameters:
- ADDR_WIDTH, 4: RAM address width, range 4-10.
- DATA_WIDTH, 4: RAM data width, range 1-256.
- RD_LAT, 0: RAM read latency in cycles. 0 = unregistered RAM output, 1 = registered RAM output. Must match the RAM's output-register setting.

Ports:
- rd_clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first RAM address to read; sampled with start.
- xfer_len  in  ADDR_WIDTH+1  number of words to read, 0..2**ADDR_WIDTH; sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at the end of a transfer.
- ram_rd_addr  out  ADDR_WIDTH  registered read address to the RAM.
- ram_rd_data  in  DATA_WIDTH  RAM read data.
- m_data  out  DATA_WIDTH  stream data, taken from the FIFO head.
- m_valid  out  1  stream valid.
- m_last  out  1  high with the final word of the transfer.
- m_ready  in  1  stream sink ready.
- stall_cnt  out  16  only present when SDPRAM_RD_STALL_CNT_EN is defined.

Behaviour:
- Interface rule: one clock, rd_clk. Reset rst is synchronous and active-high.
- Reset values: busy=0, done=0, ram_rd_addr=0, m_valid=0, m_last=0, m_data=0. FIFO is emptied, in-flight reads are discarded, state=IDLE.
- rst mid-transfer: abort on the next edge, no done pulse. Any word the RAM returns afterwards is ignored.
- State machine IDLE -> RUN -> DRAIN -> IDLE.
  - IDLE, start=1, xfer_len>0: load ram_rd_addr=base_addr and remaining=xfer_len, go to RUN.
  - IDLE, start=1, xfer_len=0: done=1 on the next cycle, busy stays 0, no beats emitted.
  - RUN: when remaining reaches 0 after an issue, go to DRAIN.
  - DRAIN: when the FIFO is empty, nothing is in flight, and the final handshake has completed, go to IDLE with done=1 for one cycle in that same cycle. busy falls with done.
  - start is ignored while busy=1.
- Issue definition: in a RUN cycle, the current ram_rd_addr is being read.
  - Issue condition: remaining>0 and (fifo_occ + inflight - pop) < 2.
  - pop = m_valid & m_ready.
  - inflight = 1 only if RD_LAT=1 and an issue happened in the previous cycle.
  - On issue: ram_rd_addr increments mod 2**ADDR_WIDTH (wraps from max to 0) and remaining decrements.
- Capture into the FIFO:
  - RD_LAT=0: ram_rd_data is captured at the end of the issue cycle.
  - RD_LAT=1: ram_rd_data is captured at the end of the cycle after issue.
  - Each captured word carries a last tag, set when it is word number xfer_len.
- FIFO: 2 entries. Push and pop in the same cycle are allowed. The issue rule guarantees no push when full. m_valid = FIFO not empty; m_data and m_last come from the head.
- Stream rule: while m_valid=1 and m_ready=0, m_data, m_last and m_valid hold stable.
- Latency with start accepted at edge 0:
  - First issue in cycle 1.
  - m_valid rises in cycle 2 (RD_LAT=0) or cycle 3 (RD_LAT=1).
- Throughput: with m_ready held at 1, one word per cycle after the first.
- The RAM's write side may update addresses not yet read. Coherence is the caller's responsibility.

Optional Feature:
- Macro: SDPRAM_RD_STALL_CNT_EN.
- Defined: stall_cnt port exists.
  - Counts cycles with m_valid=1 and m_ready=0 during a transfer.
  - Saturates at 16'hFFFF.
  - Cleared to 0 on an accepted start and on rst.
  - Holds its value after done.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- RD_LAT=0, RAM preloaded mem[i]=i, base=3, len=5, m_ready=1: beats 3,4,5,6,7 on consecutive cycles; m_last on 7; done one cycle after the last beat; busy low after.
- RD_LAT=1, base=14, len=4, ADDR_WIDTH=4: beats 14,15,0,1 (wrap); m_valid first seen in cycle 3 after start.
- Back-pressure, RD_LAT=1, len=8, m_ready toggling 1,0,0,1,... : all 8 words delivered in order, none duplicated or lost; data stable while stalled; stall_cnt equals the number of stalled-valid cycles.
- len=0 start: done pulses once, m_valid never asserts, busy stays 0. A second start while busy during a len=6 run is ignored.
- rst asserted at beat 3 of len=10: next cycle m_valid=0, busy=0, no done. A new start of len=2 from base=0 then streams 0,1 correctly.
- len=2**ADDR_WIDTH=16, base=9: exactly 16 beats 9..15,0..8; m_last on 8.
